generation_scheduler: RTL

Sequences the Game-of-Life update engine and owns the double-buffered cell memory's bank selection. It decides when a new generation is computed: free-running on the slow tick, single-step from a button, or grid clear. It hands each job to the update engine through a start/done handshake, and swaps the display bank only during VGA vertical blanking so a frame never shows a half-written generation. It sits between the debounced switch/button inputs, the tick generator, the VGA controller and the life-game datapath.

---
 rtl/generation_scheduler_if.sv | 25 ++
 rtl/generation_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/generation_scheduler_if.sv
// -----------------------------------------------------------------------------
// generation_scheduler_if
// Start/done handshake between the generation scheduler and the life-game
// update engine.
//   engine_start : one-cycle strobe launching a job    (scheduler -> engine)
//   engine_mode  : 0 = next generation, 1 = clear write bank (scheduler -> engine)
//   engine_done  : one-cycle strobe, job finished      (engine -> scheduler)
// -----------------------------------------------------------------------------
interface generation_scheduler_if;
  logic engine_start;
  logic engine_mode;
  logic engine_done;

  modport master (
    output engine_start,
    output engine_mode,
    input  engine_done
  );

  modport slave (
    input  engine_start,
    input  engine_mode,
    output engine_done
  );
endinterface

// File: rtl/generation_scheduler.sv
// -----------------------------------------------------------------------------
// generation_scheduler
// Decides when the Game-of-Life engine computes a new generation (free-run on
// tick, single step, or clear), launches engine jobs over the start/done
// handshake and swaps the display bank only during vertical blanking.
// Ports:
//   clock, reset_n    : system clock, asynchronous active-low reset
//   run               : level, 1 = free-run on tick
//   step, clear       : debounced buttons, rising edge is a request
//   tick              : one-cycle generation-period strobe
//   v_blank           : VGA vertical blanking level
//   eng (master)      : engine_start / engine_mode / engine_done handshake
//   display_bank      : bank shown by VGA; engine writes ~display_bank
//   busy              : high whenever not IDLE
//   generation        : generations since last clear/reset
//   overrun           : sticky, a compute request was dropped
// -----------------------------------------------------------------------------
module generation_scheduler #(
  parameter int GEN_COUNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       run,
  input  logic                       step,
  input  logic                       clear,
  input  logic                       tick,
  input  logic                       v_blank,
  generation_scheduler_if.master     eng,
  output logic                       display_bank,
  output logic                       busy,
  output logic [GEN_COUNT_WIDTH-1:0] generation,
  output logic                       overrun
);

  localparam logic [GEN_COUNT_WIDTH-1:0] GEN_ZERO = {GEN_COUNT_WIDTH{1'b0}};
  localparam logic [GEN_COUNT_WIDTH-1:0] GEN_ONE  = {{(GEN_COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPUTE   = 2'd1,
    ST_CLEARING  = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_n;
  logic                       r_step_prev;
  logic                       r_clear_prev;
  logic                       r_clear_pend;
  logic                       r_comp_pend;
  logic                       r_engine_start;
  logic                       r_engine_mode;
  logic                       r_display_bank;
  logic                       r_busy;
  logic                       r_overrun;
  logic [GEN_COUNT_WIDTH-1:0] r_generation;

  logic                       w_step_rise;
  logic                       w_clear_req;
  logic                       w_compute_req;
  logic                       w_swap;
  logic                       w_active;
  logic                       w_clear_q;
  logic                       w_comp_q;
  logic                       w_ovr_set;
  logic                       w_launch;
  logic                       w_start_n;
  logic                       w_mode_n;
  logic                       w_busy_n;
  logic                       w_bank_n;
  logic                       w_overrun_n;
  logic                       w_clear_pend_n;
  logic                       w_comp_pend_n;
  logic [GEN_COUNT_WIDTH-1:0] w_gen_n;

  // Request decode: step edges only count while not free-running.
  assign w_step_rise   = step & ~r_step_prev;
  assign w_clear_req   = clear & ~r_clear_prev;
  assign w_compute_req = (run & tick) | (~run & w_step_rise);
  assign w_swap        = (r_state == ST_WAIT_SWAP) & v_blank;
  assign w_active      = (r_state != ST_IDLE);

  // Pending queue including this cycle's requests. In IDLE a clear launches
  // directly, so only a simultaneous compute is left queued behind it.
  // A clear request discards any queued compute.
  assign w_clear_q = w_active & (r_clear_pend | w_clear_req);
  assign w_comp_q  = w_active ? (~w_clear_req & (r_comp_pend | (w_compute_req & ~r_clear_pend)))
                              : (w_clear_req & w_compute_req);
  assign w_ovr_set = w_active & w_compute_req & (r_clear_pend | r_comp_pend);

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_clear_req) begin
          w_state_n = ST_CLEARING;
        end else if (w_compute_req) begin
          w_state_n = ST_COMPUTE;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_COMPUTE, ST_CLEARING: begin
        if (eng.engine_done) begin
          w_state_n = ST_WAIT_SWAP;
        end else begin
          w_state_n = r_state;
        end
      end
      ST_WAIT_SWAP: begin
        if (!v_blank) begin
          w_state_n = ST_WAIT_SWAP;
        end else if (w_clear_q) begin
          w_state_n = ST_CLEARING;
        end else if (w_comp_q) begin
          w_state_n = ST_COMPUTE;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and pending flags.
  always_comb begin
    // A job launches only when entering a job state from IDLE or WAIT_SWAP,
    // which keeps engine_start from ever lasting two cycles.
    w_launch    = ((w_state_n == ST_COMPUTE) || (w_state_n == ST_CLEARING)) &&
                  ((r_state == ST_IDLE) || (r_state == ST_WAIT_SWAP));
    w_start_n   = w_launch;
    w_mode_n    = w_launch ? (w_state_n == ST_CLEARING) : r_engine_mode;
    w_busy_n    = (w_state_n != ST_IDLE);
    w_bank_n    = w_swap ? ~r_display_bank : r_display_bank;
    w_gen_n     = r_generation;
    w_overrun_n = r_overrun;
    if (w_swap) begin
      // r_engine_mode still describes the job that just finished.
      w_gen_n = r_engine_mode ? GEN_ZERO : (r_generation + GEN_ONE);
    end else begin
      w_gen_n = r_generation;
    end
    if (w_ovr_set) begin
      w_overrun_n = 1'b1;
    end else if (w_swap && r_engine_mode) begin
      w_overrun_n = 1'b0;
    end else begin
      w_overrun_n = r_overrun;
    end
    w_clear_pend_n = w_clear_q & ~(w_launch & (w_state_n == ST_CLEARING));
    w_comp_pend_n  = w_comp_q  & ~(w_launch & (w_state_n == ST_COMPUTE));
  end

  // State and output registers; button history resets high so a held
  // button does not fire on reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_step_prev    <= 1'b1;
      r_clear_prev   <= 1'b1;
      r_clear_pend   <= 1'b0;
      r_comp_pend    <= 1'b0;
      r_engine_start <= 1'b0;
      r_engine_mode  <= 1'b0;
      r_display_bank <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_generation   <= GEN_ZERO;
    end else begin
      r_state        <= w_state_n;
      r_step_prev    <= step;
      r_clear_prev   <= clear;
      r_clear_pend   <= w_clear_pend_n;
      r_comp_pend    <= w_comp_pend_n;
      r_engine_start <= w_start_n;
      r_engine_mode  <= w_mode_n;
      r_display_bank <= w_bank_n;
      r_busy         <= w_busy_n;
      r_overrun      <= w_overrun_n;
      r_generation   <= w_gen_n;
    end
  end

  assign eng.engine_start = r_engine_start;
  assign eng.engine_mode  = r_engine_mode;
  assign display_bank     = r_display_bank;
  assign busy             = r_busy;
  assign generation       = r_generation;
  assign overrun          = r_overrun;

endmodule
